dispatch: RTL and testbench

Front end of the dual-issue pipeline's issue queue: accepts up to two fetched instructions per cycle, buffers them in a 4-entry in-order instruction buffer, decodes them into `ISSUE_QUEUE_ELEMENT` records and pushes up to two per cycle into `issue_queue` through its `in_data` / `in_data_number` / `size_left` port group. It is the writer end of the issue queue, whose reader end is `issue`; it sits between fetch and `issue_queue0` in `MeMIPS`.

---
 rtl/dispatch_if.sv | 71 +++++++
 rtl/dispatch.sv | 222 ++++++++++++++++++++++
 tb/tb_dispatch.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_if.sv
// -----------------------------------------------------------------------------
// dispatch_pkg / dispatch_if
//
// Purpose : shared record type for issue-queue entries and the bus bundle that
//           connects fetch -> dispatch -> issue_queue.
//
// dispatch_pkg
//   IQ_ADDR              width of the issue queue free-entry count (size_left)
//   ISSUE_QUEUE_ELEMENT  decoded instruction record written into issue_queue
//
// dispatch_if signals
//   fetch_valid     [1:0]        per-slot valid from fetch, slot 0 older
//   fetch_inst      [1:0][31:0]  instruction words
//   fetch_pc        [1:0][31:0]  instruction PCs
//   fetch_ready                  dispatch can take two instructions this cycle
//   size_left       [IQ_ADDR-1:0] free issue-queue entries
//   in_data         [1:0]        decoded records, slot 0 older
//   in_data_number  [1:0]        records pushed into issue_queue this cycle
//
// Modports
//   master : dispatch side (consumes fetch + size_left, drives records)
//   slave  : environment side (fetch unit and issue_queue)
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int IQ_ADDR = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
    } ISSUE_QUEUE_ELEMENT;

endpackage

interface dispatch_if;
    import dispatch_pkg::*;

    logic [1:0]                fetch_valid;
    logic [1:0][31:0]          fetch_inst;
    logic [1:0][31:0]          fetch_pc;
    logic                      fetch_ready;
    logic [IQ_ADDR-1:0]        size_left;
    ISSUE_QUEUE_ELEMENT [1:0]  in_data;
    logic [1:0]                in_data_number;

    modport master (
        input  fetch_valid,
        input  fetch_inst,
        input  fetch_pc,
        input  size_left,
        output fetch_ready,
        output in_data,
        output in_data_number
    );

    modport slave (
        output fetch_valid,
        output fetch_inst,
        output fetch_pc,
        output size_left,
        input  fetch_ready,
        input  in_data,
        input  in_data_number
    );

endinterface

// File: rtl/dispatch.sv
// -----------------------------------------------------------------------------
// dispatch
//
// Purpose : writer end of the dual-issue issue queue. Accepts up to two fetched
//           instructions per cycle into a small in-order circular buffer,
//           decodes the two oldest entries into ISSUE_QUEUE_ELEMENT records and
//           offers up to two per cycle to issue_queue.
//
// Parameters
//   BUF_DEPTH   instruction buffer entries (power of two, >= 2)
//
// Ports
//   clk    in   clock
//   rst    in   synchronous, active-high reset
//   flush  in   discard every buffered instruction (redirect)
//   bus    dispatch_if.master
//            fetch_valid/fetch_inst/fetch_pc in, fetch_ready out,
//            size_left in, in_data/in_data_number out
//
// Configuration macro
//   DISPATCH_RAW_SPLIT_EN  when defined, a pair in which the younger record
//                          reads the older record's nonzero destination is
//                          split across two cycles.
//
// in_data / in_data_number are purely combinational from the registered buffer
// state and size_left; there is no same-cycle path from fetch to in_data.
// -----------------------------------------------------------------------------
module dispatch
    import dispatch_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    dispatch_if.master bus
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Highest occupancy at which two more instructions still fit.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

`ifdef DISPATCH_RAW_SPLIT_EN
    localparam bit RAW_SPLIT_EN = 1'b1;
`else
    localparam bit RAW_SPLIT_EN = 1'b0;
`endif

    // MIPS opcodes that need special handling in decode.
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } buf_entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    buf_entry_t        entry_q [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic               fetch_ready;
    logic               push_en;
    logic [1:0]         push_cnt;
    logic [1:0]         avail;
    logic [1:0]         room;
    logic [1:0]         pop_cnt;
    logic               raw_hazard;
    buf_entry_t         slot0_entry;
    buf_entry_t         slot1_entry;
    ISSUE_QUEUE_ELEMENT head0;
    ISSUE_QUEUE_ELEMENT head1;

    // -------------------------------------------------------------------------
    // Decode of one buffered instruction into an issue-queue record.
    // -------------------------------------------------------------------------
    function automatic ISSUE_QUEUE_ELEMENT decode_entry(input buf_entry_t e);
        ISSUE_QUEUE_ELEMENT r;
        logic [5:0]         op;
        op      = e.inst[31:26];
        r.valid = 1'b1;
        r.pc    = e.pc;
        r.inst  = e.inst;
        r.rs    = e.inst[25:21];
        r.rt    = e.inst[20:16];

        // R-type writes rd, JAL writes $ra, stores/branches/J write nothing,
        // every other I-type writes rt.
        if (op == OP_SPECIAL) begin
            r.dest = e.inst[15:11];
        end else if (op == OP_JAL) begin
            r.dest = 5'd31;
        end else if (op inside {6'h01, 6'h02, [6'h04:6'h07], [6'h28:6'h2B]}) begin
            r.dest = 5'd0;
        end else begin
            r.dest = e.inst[20:16];
        end

        // Logical immediates are zero-extended, LUI pre-shifts into the upper
        // half, everything else sign-extends.
        if (op inside {OP_ANDI, OP_ORI, OP_XORI}) begin
            r.imm = {16'h0000, e.inst[15:0]};
        end else if (op == OP_LUI) begin
            r.imm = {e.inst[15:0], 16'h0000};
        end else begin
            r.imm = {{16{e.inst[15]}}, e.inst[15:0]};
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Push side: accept fetch only when two entries are guaranteed free, based
    // on registered occupancy so fetch_ready never depends on this cycle's pop.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        fetch_ready = (count_q <= READY_MAX);
        push_en     = fetch_ready && !flush;
        push_cnt    = 2'd0;
        slot0_entry = '{pc: bus.fetch_pc[0], inst: bus.fetch_inst[0]};
        slot1_entry = '{pc: bus.fetch_pc[1], inst: bus.fetch_inst[1]};
        if (push_en) begin
            push_cnt = {1'b0, bus.fetch_valid[0]} + {1'b0, bus.fetch_valid[1]};
        end
    end

    // -------------------------------------------------------------------------
    // Pop side: n = min(count, 2, size_left, 2), optionally split on RAW.
    // -------------------------------------------------------------------------
    always_comb begin
        head0 = decode_entry(entry_q[rd_ptr_q]);
        // The second head entry may be stale when count < 2; it is then masked
        // out below because pop_cnt cannot reach 2.
        head1 = decode_entry(entry_q[rd_ptr_q + PTR_W'(1)]);

        avail = (count_q >= CNT_TWO) ? 2'd2 : count_q[1:0];
        room  = (bus.size_left >= IQ_ADDR'(2)) ? 2'd2 : bus.size_left[1:0];

        raw_hazard = (head0.dest != 5'd0) &&
                     ((head1.rs == head0.dest) || (head1.rt == head0.dest));

        pop_cnt = (avail < room) ? avail : room;
        if (RAW_SPLIT_EN && (pop_cnt == 2'd2) && raw_hazard) begin
            pop_cnt = 2'd1;
        end
        // A redirect kills the whole buffer, so nothing may leave in that cycle.
        if (flush) begin
            pop_cnt = 2'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.fetch_ready    = fetch_ready;
        bus.in_data_number = pop_cnt;
        bus.in_data[0]     = (pop_cnt != 2'd0) ? head0 : '0;
        bus.in_data[1]     = (pop_cnt == 2'd2) ? head1 : '0;
    end

    // -------------------------------------------------------------------------
    // Next-state for pointers and occupancy. Flush has priority over all
    // other events.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
        count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the buffer storage is deliberately not reset; count_q alone says
    // which entries are live and slots beyond it are zeroed at the output.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (bus.fetch_valid[0]) begin
                entry_q[wr_ptr_q] <= slot0_entry;
                if (bus.fetch_valid[1]) begin
                    entry_q[wr_ptr_q + PTR_W'(1)] <= slot1_entry;
                end
            end else if (bus.fetch_valid[1]) begin
                // Illegal 2'b10 pattern: keep the buffer compact anyway.
                entry_q[wr_ptr_q] <= slot1_entry;
            end
        end
    end

endmodule

// File: tb/tb_dispatch.sv
// -----------------------------------------------------------------------------
// tb_dispatch
//
// Purpose : self-checking bench for dispatch. A scoreboard queue receives every
//           instruction the fetch side successfully pushes; a negedge monitor
//           pops the expected records when the DUT offers them and compares
//           fetch_ready, in_data_number and both in_data slots each cycle.
//           Scenario tasks add directed checks against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dispatch;
    import dispatch_pkg::*;

    localparam int BUF_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    dispatch_if bus ();

    dispatch #(.BUF_DEPTH(BUF_DEPTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    fetch_t model_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;

    // Instruction words used by the directed scenarios.
    localparam logic [31:0] I_ADDU_3_1_2 = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] I_ADDU_4_3_3 = 32'h0063_2021; // addu $4,$3,$3
    localparam logic [31:0] I_ORI_5_6    = 32'h34C5_8001; // ori  $5,$6,0x8001
    localparam logic [31:0] I_JAL        = 32'h0C00_0010; // jal  0x40
    localparam logic [31:0] I_SW         = 32'hAFA5_FFFC; // sw   $5,-4($29)
    localparam logic [31:0] I_LUI        = 32'h3C07_1234; // lui  $7,0x1234
    localparam logic [31:0] I_BEQ        = 32'h1022_0003; // beq  $1,$2,3
    localparam logic [31:0] I_ADDIU_A    = 32'h2528_0000; // addiu $8,$9,imm
    localparam logic [31:0] I_ADDIU_B    = 32'h256A_0000; // addiu $10,$11,imm

    // Reference decoder, written as a plain opcode table.
    function automatic ISSUE_QUEUE_ELEMENT ref_decode(input logic [31:0] inst,
                                                      input logic [31:0] pc);
        ISSUE_QUEUE_ELEMENT r;
        r       = '0;
        r.valid = 1'b1;
        r.pc    = pc;
        r.inst  = inst;
        r.rs    = inst[25:21];
        r.rt    = inst[20:16];
        case (inst[31:26])
            6'h00:                                    r.dest = inst[15:11];
            6'h03:                                    r.dest = 5'd31;
            6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h28, 6'h29, 6'h2A, 6'h2B:               r.dest = 5'd0;
            default:                                  r.dest = inst[20:16];
        endcase
        case (inst[31:26])
            6'h0C, 6'h0D, 6'h0E: r.imm = {16'h0000, inst[15:0]};
            6'h0F:               r.imm = {inst[15:0], 16'h0000};
            default:             r.imm = {{16{inst[15]}}, inst[15:0]};
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Scoreboard monitor
    // -------------------------------------------------------------------------
    int                 m_cnt;
    int                 m_n;
    logic               m_ready;
    ISSUE_QUEUE_ELEMENT m_r0, m_r1, m_rec;
    fetch_t             m_f;

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
        end else if (mon_en) begin
            m_cnt   = model_q.size();
            m_ready = (m_cnt <= BUF_DEPTH - 2);
            checks++;
            if (bus.fetch_ready !== m_ready) begin
                errors++;
                $display("FAIL sb_fetch_ready t=%0t got %b want %b", $time, bus.fetch_ready, m_ready);
            end

            if (flush) begin
                m_n = 0;
            end else begin
                m_n = (m_cnt < 2) ? m_cnt : 2;
                if (int'(bus.size_left) < m_n) m_n = int'(bus.size_left);
            end
            if (m_n == 2) begin
                m_r0 = ref_decode(model_q[0].inst, model_q[0].pc);
                m_r1 = ref_decode(model_q[1].inst, model_q[1].pc);
`ifdef DISPATCH_RAW_SPLIT_EN
                if (m_r0.dest != 5'd0 && (m_r1.rs == m_r0.dest || m_r1.rt == m_r0.dest)) m_n = 1;
`endif
            end
            checks++;
            if (int'(bus.in_data_number) != m_n) begin
                errors++;
                $display("FAIL sb_number t=%0t got %0d want %0d", $time, bus.in_data_number, m_n);
            end
            for (int k = 0; k < 2; k++) begin
                m_rec = '0;
                if (k < m_n) m_rec = ref_decode(model_q[k].inst, model_q[k].pc);
                checks++;
                if (bus.in_data[k] !== m_rec) begin
                    errors++;
                    $display("FAIL sb_slot%0d t=%0t got %h want %h", k, $time, bus.in_data[k], m_rec);
                end
            end

            if (flush) begin
                model_q.delete();
            end else begin
                for (int k = 0; k < m_n; k++) void'(model_q.pop_front());
                if (m_ready) begin
                    for (int k = 0; k < 2; k++) begin
                        if (bus.fetch_valid[k]) begin
                            m_f.pc   = bus.fetch_pc[k];
                            m_f.inst = bus.fetch_inst[k];
                            model_q.push_back(m_f);
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive(input logic [1:0] v,
                         input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [IQ_ADDR-1:0] sl, input logic fl);
        @(posedge clk);
        #1;
        bus.fetch_valid   = v;
        bus.fetch_inst[0] = i0;
        bus.fetch_pc[0]   = p0;
        bus.fetch_inst[1] = i1;
        bus.fetch_pc[1]   = p1;
        bus.size_left     = sl;
        flush             = fl;
    endtask

    task automatic idle(input int cycles, input logic [IQ_ADDR-1:0] sl);
        repeat (cycles) drive(2'b00, '0, '0, '0, '0, sl, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset;
        bus.size_left = 4'd8;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fetch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", bus.fetch_ready);
        end
        checks++;
        if (bus.in_data_number !== 2'd0) begin
            errors++; $display("FAIL reset_number got %0d want 0", bus.in_data_number);
        end
        checks++;
        if (bus.in_data !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", bus.in_data);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        drive(2'b11, I_ADDU_3_1_2, 32'h0, I_ORI_5_6, 32'h4, 4'd8, 1'b0);
        drive(2'b00, '0, '0, '0, '0, 4'd8, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_data_number !== 2'd2) begin
            errors++; $display("FAIL basic_number got %0d want 2", bus.in_data_number);
        end
        checks++;
        if (bus.in_data[0].dest !== 5'd3) begin
            errors++; $display("FAIL basic_addu_dest got %0d want 3", bus.in_data[0].dest);
        end
        checks++;
        if (bus.in_data[1].imm !== 32'h0000_8001) begin
            errors++; $display("FAIL basic_ori_imm got %h want 00008001", bus.in_data[1].imm);
        end
        checks++;
        if (bus.in_data[1].dest !== 5'd5) begin
            errors++; $display("FAIL basic_ori_dest got %0d want 5", bus.in_data[1].dest);
        end
        idle(2, 4'd8);
    endtask

    task automatic test_fill_stall;
        logic exp_ready [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        drive(2'b11, I_ADDIU_A | 32'h100, 32'h100, I_ADDIU_B | 32'h104, 32'h104, 4'd0, 1'b0);
        drive(2'b11, I_ADDIU_A | 32'h108, 32'h108, I_ADDIU_B | 32'h10C, 32'h10C, 4'd0, 1'b0);
        // Buffer is full now; this pair must be dropped.
        drive(2'b11, I_ADDIU_A | 32'h110, 32'h110, I_ADDIU_B | 32'h114, 32'h114, 4'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.fetch_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b want 0", bus.fetch_ready);
        end
        checks++;
        if (bus.in_data_number !== 2'd0) begin
            errors++; $display("FAIL full_number got %0d want 0", bus.in_data_number);
        end
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, '0, '0, '0, '0, 4'd1, 1'b0);
            @(negedge clk);
            checks++;
            if (bus.in_data_number !== 2'd1) begin
                errors++; $display("FAIL trickle_number[%0d] got %0d want 1", k, bus.in_data_number);
            end
            checks++;
            if (bus.fetch_ready !== exp_ready[k]) begin
                errors++; $display("FAIL trickle_ready[%0d] got %b want %b", k, bus.fetch_ready, exp_ready[k]);
            end
            checks++;
            if (bus.in_data[0].pc !== 32'h100 + 32'(4 * k)) begin
                errors++; $display("FAIL trickle_pc[%0d] got %h want %h", k, bus.in_data[0].pc, 32'h100 + 32'(4 * k));
            end
        end
        idle(2, 4'd8);
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc      = 32'h200;
        logic [31:0] exp_pop = 32'h200;
        repeat (2) begin
            drive(2'b11, I_ADDIU_A | pc, pc, I_ADDIU_B | (pc + 4), pc + 4, 4'd0, 1'b0);
            pc += 8;
        end
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, I_ADDIU_A | pc, pc, I_ADDIU_B | (pc + 4), pc + 4, 4'd5, 1'b0);
            @(negedge clk);
            checks++;
            if (bus.in_data_number !== 2'd2) begin
                errors++; $display("FAIL b2b_number[%0d] got %0d want 2", k, bus.in_data_number);
            end
            checks++;
            if (bus.in_data[0].pc !== exp_pop || bus.in_data[1].pc !== exp_pop + 4) begin
                errors++;
                $display("FAIL b2b_order[%0d] got %h,%h want %h,%h", k, bus.in_data[0].pc,
                         bus.in_data[1].pc, exp_pop, exp_pop + 4);
            end
            exp_pop += 8;
            // Fetch holds its pair until the buffer accepts it.
            if (bus.fetch_ready) pc += 8;
        end
        idle(3, 4'd8);
    endtask

    task automatic test_flush;
        drive(2'b11, I_ADDIU_A, 32'h300, I_ADDIU_B, 32'h304, 4'd0, 1'b0);
        drive(2'b01, I_ADDIU_A, 32'h308, '0, '0, 4'd0, 1'b0);
        drive(2'b11, I_ADDIU_A, 32'h30C, I_ADDIU_B, 32'h310, 4'd4, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_data_number !== 2'd0) begin
            errors++; $display("FAIL flush_cycle_number got %0d want 0", bus.in_data_number);
        end
        drive(2'b00, '0, '0, '0, '0, 4'd4, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_data_number !== 2'd0) begin
            errors++; $display("FAIL flush_after_number got %0d want 0", bus.in_data_number);
        end
        checks++;
        if (bus.fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after_ready got %b want 1", bus.fetch_ready);
        end
        idle(1, 4'd8);
    endtask

    task automatic test_split;
        drive(2'b11, I_ADDU_3_1_2, 32'h400, I_ADDU_4_3_3, 32'h404, 4'd4, 1'b0);
        drive(2'b00, '0, '0, '0, '0, 4'd4, 1'b0);
        @(negedge clk);
`ifdef DISPATCH_RAW_SPLIT_EN
        checks++;
        if (bus.in_data_number !== 2'd1 || bus.in_data[0].pc !== 32'h400) begin
            errors++; $display("FAIL split_first got n=%0d pc=%h want n=1 pc=400", bus.in_data_number, bus.in_data[0].pc);
        end
        drive(2'b00, '0, '0, '0, '0, 4'd4, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_data_number !== 2'd1 || bus.in_data[0].pc !== 32'h404) begin
            errors++; $display("FAIL split_second got n=%0d pc=%h want n=1 pc=404", bus.in_data_number, bus.in_data[0].pc);
        end
`else
        checks++;
        if (bus.in_data_number !== 2'd2) begin
            errors++; $display("FAIL nosplit_number got %0d want 2", bus.in_data_number);
        end
`endif
        idle(2, 4'd8);
    endtask

    task automatic test_decode;
        drive(2'b11, I_JAL, 32'h500, I_SW, 32'h504, 4'd8, 1'b0);
        drive(2'b11, I_LUI, 32'h508, I_BEQ, 32'h50C, 4'd8, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_data[0].dest !== 5'd31) begin
            errors++; $display("FAIL jal_dest got %0d want 31", bus.in_data[0].dest);
        end
        checks++;
        if (bus.in_data[1].dest !== 5'd0 || bus.in_data[1].imm !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL sw_decode got dest=%0d imm=%h want 0 fffffffc", bus.in_data[1].dest, bus.in_data[1].imm);
        end
        drive(2'b00, '0, '0, '0, '0, 4'd8, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_data[0].imm !== 32'h1234_0000 || bus.in_data[0].dest !== 5'd7) begin
            errors++; $display("FAIL lui_decode got imm=%h dest=%0d want 12340000 7", bus.in_data[0].imm, bus.in_data[0].dest);
        end
        checks++;
        if (bus.in_data[1].dest !== 5'd0 || bus.in_data[1].imm !== 32'h0000_0003) begin
            errors++; $display("FAIL beq_decode got dest=%0d imm=%h want 0 00000003", bus.in_data[1].dest, bus.in_data[1].imm);
        end
        idle(2, 4'd8);
    endtask

    task automatic test_reset_mid;
        drive(2'b11, I_ADDIU_A, 32'h600, I_ADDIU_B, 32'h604, 4'd0, 1'b0);
        drive(2'b11, I_ADDIU_A, 32'h608, I_ADDIU_B, 32'h60C, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.fetch_valid = 2'b00;
        bus.size_left   = 4'd8;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fetch_ready !== 1'b1 || bus.in_data_number !== 2'd0) begin
            errors++; $display("FAIL midreset got ready=%b n=%0d want 1 0", bus.fetch_ready, bus.in_data_number);
        end
        checks++;
        if (bus.in_data !== '0) begin
            errors++; $display("FAIL midreset_data got %h want 0", bus.in_data);
        end
        idle(1, 4'd8);
    endtask

    task automatic test_random;
        logic [5:0]  ops [8] = '{6'h00, 6'h03, 6'h2B, 6'h0F, 6'h0D, 6'h04, 6'h09, 6'h23};
        logic [31:0] pc = 32'h1000;
        logic [31:0] r0, r1;
        logic [1:0]  v;
        for (int i = 0; i < 300; i++) begin
            r0 = $urandom();
            r1 = $urandom();
            r0[31:26] = ops[$urandom_range(0, 7)];
            r1[31:26] = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 2))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            drive(v, r0, pc, r1, pc + 4, 4'($urandom_range(0, 4)),
                  ($urandom_range(0, 15) == 0));
            pc += 8;
        end
        idle(4, 4'd8);
    endtask

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.fetch_valid = 2'b00;
        bus.fetch_inst  = '0;
        bus.fetch_pc    = '0;
        bus.size_left   = '0;

        test_reset();
        test_basic();
        test_fill_stall();
        test_back_to_back();
        test_flush();
        test_split();
        test_decode();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
